cell_processor_seq: RTL

- Parametrised, sequential successor to the combinational cell-processing functions.
- Accepts one instruction per handshake: two cells, one user immediate and an opcode. Produces one result pixel on a valid/ready output.
- Generalises channel width, channel count and cell size.
- Adds exact multi-cycle averaging, optional saturation, backpressure and an illegal-opcode flag.
- Sits between the cell-fetch/line-buffer stage and the output image writer.

---
 rtl/cell_processor_seq_pkg.sv | 40 ++++
 rtl/cell_channel_alu.sv | 62 ++++++
 rtl/cell_processor_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cell_processor_seq_pkg.sv
// Shared types for the cell processor: opcode and FSM enums, default widths, centre-pixel helper.
// Consumers import CellProcessingPkg::*.
package CellProcessingPkg;

    localparam int DEF_CHANNEL_WIDTH = 8;
    localparam int DEF_CHANNEL_NUM   = 3;
    localparam int DEF_CELL_N        = 3;
    localparam int DEF_OPCODE_WIDTH  = 4;

    typedef enum logic [DEF_OPCODE_WIDTH-1:0] {
        OP_ADD   = 0,
        OP_ADDI  = 1,
        OP_SUB   = 2,
        OP_SUBI  = 3,
        OP_MULT  = 4,
        OP_MULTI = 5,
        OP_DIV2  = 6,
        OP_INV   = 7,
        OP_AND   = 8,
        OP_OR    = 9,
        OP_NOR   = 10,
        OP_AVG   = 11
    } cellOpcode_e;

    // First opcode value that is not a defined operation.
    localparam int OP_LEGAL_COUNT = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        AVG_ACC = 2'd2,
        HOLD    = 2'd3
    } cellState_e;

    // Row-major index of the centre pixel of a CELL_N x CELL_N cell.
    function automatic int centreIdx(input int cellN);
        return (cellN / 2) * cellN + (cellN / 2);
    endfunction

endpackage

// File: rtl/cell_channel_alu.sv
// Single-channel combinational ALU for the cell processor; zero latency, no flow control.
// Wraps modulo 2^CHANNEL_WIDTH by default, clamps when CELL_PROC_SATURATE_EN is defined.
module cell_channel_alu
    import CellProcessingPkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH
) (
    input  logic [CHANNEL_WIDTH-1:0] a,
    input  logic [CHANNEL_WIDTH-1:0] b,
    input  logic [OPCODE_WIDTH-1:0]  opcode,
    output logic [CHANNEL_WIDTH-1:0] result,
    output logic                     illegal
);

    logic [CHANNEL_WIDTH-1:0] addRes;
    logic [CHANNEL_WIDTH-1:0] subRes;
    logic [CHANNEL_WIDTH-1:0] mulRes;

`ifdef CELL_PROC_SATURATE_EN
    localparam logic [CHANNEL_WIDTH-1:0] CHAN_MAX = '1;

    logic [CHANNEL_WIDTH:0]         sumWide;
    logic [CHANNEL_WIDTH:0]         diffWide;
    logic [2*CHANNEL_WIDTH-1:0]     prodWide;

    assign sumWide  = {1'b0, a} + {1'b0, b};
    assign diffWide = {1'b0, a} - {1'b0, b};
    assign prodWide = (2*CHANNEL_WIDTH)'(a) * (2*CHANNEL_WIDTH)'(b);

    // A borrow out of the extended subtraction means the true result went negative.
    assign addRes = sumWide[CHANNEL_WIDTH] ? CHAN_MAX : sumWide[CHANNEL_WIDTH-1:0];
    assign subRes = diffWide[CHANNEL_WIDTH] ? '0 : diffWide[CHANNEL_WIDTH-1:0];
    assign mulRes = (|prodWide[2*CHANNEL_WIDTH-1:CHANNEL_WIDTH]) ? CHAN_MAX
                                                                 : prodWide[CHANNEL_WIDTH-1:0];
`else
    assign addRes = a + b;
    assign subRes = a - b;
    assign mulRes = a * b;
`endif

    always_comb begin
        result  = a;
        illegal = 1'b0;
        if (opcode >= OPCODE_WIDTH'(OP_LEGAL_COUNT)) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPCODE_WIDTH'(OP_ADD),  OPCODE_WIDTH'(OP_ADDI):  result = addRes;
                OPCODE_WIDTH'(OP_SUB),  OPCODE_WIDTH'(OP_SUBI):  result = subRes;
                OPCODE_WIDTH'(OP_MULT), OPCODE_WIDTH'(OP_MULTI): result = mulRes;
                OPCODE_WIDTH'(OP_DIV2): result = a >> 1;
                OPCODE_WIDTH'(OP_INV):  result = ~a;
                OPCODE_WIDTH'(OP_AND):  result = a & b;
                OPCODE_WIDTH'(OP_OR):   result = a | b;
                OPCODE_WIDTH'(OP_NOR):  result = ~(a | b);
                default:                result = a;
            endcase
        end
    end

endmodule

// File: rtl/cell_processor_seq.sv
// Sequential cell processor: one instruction in, one pixel out; optional clamp via CELL_PROC_SATURATE_EN.
// Latency accept->out_valid: 2 cycles, AVG CELL_N^2+1 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE.
module cell_processor_seq
    import CellProcessingPkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int CHANNEL_NUM   = DEF_CHANNEL_NUM,
    parameter int CELL_N        = DEF_CELL_N,
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [CELL_N*CELL_N*CHANNEL_NUM*CHANNEL_WIDTH-1:0] in_cell_a,
    input  logic [CELL_N*CELL_N*CHANNEL_NUM*CHANNEL_WIDTH-1:0] in_cell_b,
    input  logic [CHANNEL_WIDTH-1:0]                      in_user,
    input  logic [OPCODE_WIDTH-1:0]                       in_opcode,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [CHANNEL_NUM*CHANNEL_WIDTH-1:0]          out_pixel,
    output logic                                          out_err,
    output logic                                          busy
);

    localparam int PIX_W    = CHANNEL_NUM * CHANNEL_WIDTH;
    localparam int CELL_PIX = CELL_N * CELL_N;
    localparam int CNT_W    = $clog2(CELL_PIX);
    localparam int ACC_W    = CHANNEL_WIDTH + $clog2(CELL_PIX);
    localparam int CENTRE   = centreIdx(CELL_N);

    cellState_e state;
    cellState_e stateNext;

    logic [CELL_PIX-1:0][PIX_W-1:0]      cellA;
    logic [PIX_W-1:0]                    centreB;
    logic [CHANNEL_WIDTH-1:0]            userImm;
    logic [OPCODE_WIDTH-1:0]             opcode;
    logic [CNT_W-1:0]                    pixCnt;
    logic [CHANNEL_NUM-1:0][ACC_W-1:0]   acc;
    logic [CHANNEL_NUM-1:0][ACC_W-1:0]   accSum;

    logic [PIX_W-1:0]        centreA;
    logic [PIX_W-1:0]        curPix;
    logic [PIX_W-1:0]        aluPixel;
    logic [PIX_W-1:0]        avgPixel;
    logic [CHANNEL_NUM-1:0]  aluIllegal;
    logic                    useImm;
    logic                    lastPix;
    logic                    accept;
    logic                    unusedCellB;

    // Only the centre of cell B is ever consumed.
    assign unusedCellB = ^in_cell_b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign centreA = cellA[CENTRE];
    assign curPix  = cellA[pixCnt];
    assign lastPix = (pixCnt == CNT_W'(CELL_PIX - 1));
    assign useImm  = (opcode == OPCODE_WIDTH'(OP_ADDI)) ||
                     (opcode == OPCODE_WIDTH'(OP_SUBI)) ||
                     (opcode == OPCODE_WIDTH'(OP_MULTI));

    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : gChan
        logic [CHANNEL_WIDTH-1:0] bOperand;

        assign bOperand = useImm ? userImm : centreB[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH];

        cell_channel_alu #(
            .CHANNEL_WIDTH (CHANNEL_WIDTH),
            .OPCODE_WIDTH  (OPCODE_WIDTH)
        ) uAlu (
            .a       (centreA[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .b       (bOperand),
            .opcode  (opcode),
            .result  (aluPixel[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .illegal (aluIllegal[ch])
        );

        // The final add and the constant divide share the last accumulation cycle.
        assign accSum[ch] = acc[ch] + ACC_W'(curPix[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
        assign avgPixel[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
            CHANNEL_WIDTH'(accSum[ch] / ACC_W'(CELL_PIX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (in_opcode == OPCODE_WIDTH'(OP_AVG)) ? AVG_ACC : EXEC;
                end
            end
            EXEC:    stateNext = HOLD;
            AVG_ACC: if (lastPix) stateNext = HOLD;
            HOLD:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cellA     <= '0;
            centreB   <= '0;
            userImm   <= '0;
            opcode    <= '0;
            pixCnt    <= '0;
            acc       <= '0;
            out_pixel <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cellA   <= in_cell_a;
                        centreB <= in_cell_b[CENTRE*PIX_W +: PIX_W];
                        userImm <= in_user;
                        opcode  <= in_opcode;
                        pixCnt  <= '0;
                        acc     <= '0;
                    end
                end
                EXEC: begin
                    out_pixel <= aluPixel;
                    out_err   <= |aluIllegal;
                end
                AVG_ACC: begin
                    acc    <= accSum;
                    pixCnt <= pixCnt + CNT_W'(1);
                    if (lastPix) begin
                        out_pixel <= avgPixel;
                        out_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
